markov_lane_scheduler: RTL and testbench

//   Per-lane bit accumulator and round-robin output scheduler for the TRNG Markov post-processor.

---
 rtl/markov_lane_scheduler.sv | 144 ++++++++++++++
 tb/tb_markov_lane_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/markov_lane_scheduler.sv
// Per-lane bit accumulator with a round-robin output scheduler for the TRNG Markov post-processor.
// Each raw bit is packed into the word of its Markov lane. Completed lane words are arbitrated
// onto one valid/ready output stream.
// Optional feature macro: MARKOV_DROP_CNT_EN adds the saturating 16-bit drop_cnt output.
module markov_lane_scheduler #(
    parameter int unsigned LANE_W = 4,
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic [LANE_W-1:0] lane,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [LANE_W-1:0] out_lane
`ifdef MARKOV_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int unsigned NUM_LANES = 1 << LANE_W;
    localparam int unsigned CNT_W     = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] acc_q [NUM_LANES];
    logic [WORD_W-1:0] acc_d [NUM_LANES];
    logic [CNT_W-1:0]  cnt_q [NUM_LANES];
    logic [CNT_W-1:0]  cnt_d [NUM_LANES];
    logic [LANE_W-1:0] ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_word_q, out_word_d;
    logic [LANE_W-1:0] out_lane_q, out_lane_d;

    logic [NUM_LANES-1:0] lane_full;
    logic                 grant_found;
    logic [LANE_W-1:0]    grant_lane;
    logic [LANE_W-1:0]    search_idx;
    logic                 grant_en;
    logic                 same_lane_grant;

    // A lane is FULL once its registered count reaches WORD_W.
    always_comb begin
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            lane_full[l] = (cnt_q[l] == CNT_W'(WORD_W));
        end
    end

    // Round-robin search for the first FULL lane at or above ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_lane  = '0;
        search_idx  = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            search_idx = ptr_q + LANE_W'(i);
            if (!grant_found && lane_full[search_idx]) begin
                grant_found = 1'b1;
                grant_lane  = search_idx;
            end
        end
    end

    // Output holding register, lane accumulators and round-robin pointer update.
    always_comb begin
        acc_d           = acc_q;
        cnt_d           = cnt_q;
        ptr_d           = ptr_q;
        out_valid_d     = out_valid_q;
        out_word_d      = out_word_q;
        out_lane_d      = out_lane_q;
        grant_en        = (!out_valid_q || out_ready) && grant_found;
        same_lane_grant = grant_en && (grant_lane == lane);

        if (grant_en) begin
            out_valid_d       = 1'b1;
            out_word_d        = acc_q[grant_lane];
            out_lane_d        = grant_lane;
            cnt_d[grant_lane] = '0;
            ptr_d             = grant_lane + LANE_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A bit on a lane being granted this cycle starts that lane's next word.
        if (bit_valid && (!lane_full[lane] || same_lane_grant)) begin
            acc_d[lane] = {acc_q[lane][WORD_W-2:0], bit_in};
            cnt_d[lane] = same_lane_grant ? CNT_W'(1) : cnt_q[lane] + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                acc_q[l] <= '0;
                cnt_q[l] <= '0;
            end
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_lane_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_lane_q  <= out_lane_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_lane  = out_lane_q;

`ifdef MARKOV_DROP_CNT_EN
    logic        bit_drop;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of bits discarded because their lane was FULL and not granted.
    always_comb begin
        bit_drop   = bit_valid && lane_full[lane] && !same_lane_grant;
        drop_cnt_d = drop_cnt_q;
        if (bit_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    // Without the drop counter, dropped bits are silently discarded.
`endif

endmodule

// File: tb/tb_markov_lane_scheduler.sv
// Directed self-checking bench for markov_lane_scheduler.
module tb_markov_lane_scheduler;

    logic       clk;
    logic       reset;
    logic       bit_valid;
    logic       bit_in;
    logic [3:0] lane;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_word;
    logic [3:0] out_lane;
`ifdef MARKOV_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    markov_lane_scheduler #(.LANE_W(4), .WORD_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .lane      (lane),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_lane  (out_lane)
`ifdef MARKOV_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic [3:0] l, input logic b);
        bit_valid = 1'b1;
        lane      = l;
        bit_in    = b;
        tick();
    endtask

    task automatic send_word(input logic [3:0] l, input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            send_bit(l, w[i]);
        end
        bit_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] w, input logic [3:0] l);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_word"},  32'(out_word),  32'(w));
        check({tag, "_lane"},  32'(out_lane),  32'(l));
    endtask

    initial begin
        // 1: reset with random inputs
        reset     = 1'b1;
        bit_valid = 1'($urandom);
        bit_in    = 1'($urandom);
        lane      = 4'($urandom);
        out_ready = 1'($urandom);
        tick();
        bit_valid = 1'($urandom);
        bit_in    = 1'($urandom);
        lane      = 4'($urandom);
        tick();
        check_out("reset", 1'b0, 8'h00, 4'd0);
`ifdef MARKOV_DROP_CNT_EN
        check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        reset     = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b1;

        // 2: single word on lane 3, one-cycle output pulse
        send_word(4'd3, 8'hB2);
        check("t2_not_yet", 32'(out_valid), 32'd0);
        tick();
        check_out("t2_word", 1'b1, 8'hB2, 4'd3);
        tick();
        check("t2_pulse_end", 32'(out_valid), 32'd0);

        // 3: round-robin ordering; reset to put ptr at 0 first
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b0;
        send_word(4'd15, 8'h0F);
        tick();
        check_out("t3_hold15", 1'b1, 8'h0F, 4'd15);
        send_word(4'd5, 8'h55);
        send_word(4'd2, 8'h22);
        tick();
        check_out("t3_still15", 1'b1, 8'h0F, 4'd15);
        out_ready = 1'b1;
        tick();
        check_out("t3_first2", 1'b1, 8'h22, 4'd2);
        tick();
        check_out("t3_then5", 1'b1, 8'h55, 4'd5);
        out_ready = 1'b0;
        send_word(4'd1, 8'h11);
        send_word(4'd7, 8'h77);
        check_out("t3_hold5", 1'b1, 8'h55, 4'd5);
        out_ready = 1'b1;
        tick();
        check_out("t3_first7", 1'b1, 8'h77, 4'd7);
        tick();
        check_out("t3_then1", 1'b1, 8'h11, 4'd1);
        tick();
        check("t3_idle", 32'(out_valid), 32'd0);

        // 4: hold stability with lane 4 FULL behind it, and a dropped bit
        out_ready = 1'b0;
        send_word(4'd4, 8'hC3);
        tick();
        check_out("t4_hold", 1'b1, 8'hC3, 4'd4);
        send_word(4'd4, 8'h96);
        send_bit(4'd4, 1'b1);
        bit_valid = 1'b0;
`ifdef MARKOV_DROP_CNT_EN
        check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        for (int i = 0; i < 20; i++) begin
            tick();
            check_out("t4_stable", 1'b1, 8'hC3, 4'd4);
        end
        out_ready = 1'b1;
        tick();
        check_out("t4_next", 1'b1, 8'h96, 4'd4);
        tick();
        check("t4_idle", 32'(out_valid), 32'd0);

        // 5: new bit on lane 6 in its grant cycle starts the next word
        for (int i = 0; i < 8; i++) begin
            send_bit(4'd6, 1'b1);
        end
        send_bit(4'd6, 1'b0);
        check_out("t5_ff", 1'b1, 8'hFF, 4'd6);
        send_bit(4'd6, 1'b1);
        check("t5_gap", 32'(out_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            send_bit(4'd6, 1'b1);
        end
        bit_valid = 1'b0;
        tick();
        check_out("t5_7f", 1'b1, 8'h7F, 4'd6);
`ifdef MARKOV_DROP_CNT_EN
        check("t5_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        tick();
        check("t5_idle", 32'(out_valid), 32'd0);

        // 6: reset discards a partial word
        for (int i = 0; i < 5; i++) begin
            send_bit(4'd0, 1'b1);
        end
        bit_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
`ifdef MARKOV_DROP_CNT_EN
        check("t6_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        send_word(4'd0, 8'h5A);
        check("t6_not_yet", 32'(out_valid), 32'd0);
        tick();
        check_out("t6_word", 1'b1, 8'h5A, 4'd0);
        tick();
        check("t6_single", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        check("t6_no_extra", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
